// File: rtl/router_egress_buffer_if.sv
// router_egress_buffer_if
//   Stream bundle for one router egress lane. The upstream side carries the
//   router's out_data/out_valid pair (no backpressure). The downstream side is
//   a valid/ready stream toward the port consumer.
// Signals
//   in_data    word from the router lane
//   in_valid   router out_valid bit for this lane
//   out_data   head-of-FIFO word (zero when nothing is held)
//   out_valid  head word available
//   out_ready  consumer accepts the head word this cycle
// Modports
//   master  environment side: drives the input lane and out_ready
//   slave   buffer side: consumes the input lane, drives out_data/out_valid
interface router_egress_buffer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output out_data,
    output out_valid
  );
endinterface

// File: rtl/router_egress_buffer.sv
// router_egress_buffer
//   Per-port egress FIFO that sits directly behind one router output lane.
//   The router cannot be stalled, so every valid word is either stored or,
//   when the FIFO is full and nothing leaves that cycle, dropped and counted.
//   The consumer side is first-word-fall-through valid/ready.
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-low
//   bus          stream bundle (slave modport): in_data/in_valid from the
//                router, out_data/out_valid/out_ready toward the consumer
//   full         level == DEPTH
//   empty        level == 0
//   level        current occupancy, 0..DEPTH
//   drop_count   words lost to overflow, saturating at all-ones
//   clear_drops  synchronous clear of drop_count
module router_egress_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  router_egress_buffer_if.slave      bus,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_WIDTH-1:0]       drop_count,
  input  logic                       clear_drops
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  overflow;

  // Status flags come straight from the registered level, so every slot is
  // usable and no pointer-comparison ambiguity exists between full and empty.
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

  // A full FIFO can still accept a word when the head leaves the same cycle.
  // Pop depends only on registered state, so an empty FIFO never bypasses.
  assign pop      = bus.out_valid && bus.out_ready;
  assign push     = bus.in_valid && (!full || pop);
  assign overflow = bus.in_valid && full && !pop;

  // Head word is forced to zero whenever nothing is held, so stale array
  // contents never leak to the consumer.
  assign bus.out_valid = !empty;
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;

  // Storage array carries no reset; the pointers and level decide what is
  // live, so discarding contents on reset only needs the control state cleared.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
  // pointers wrap from DEPTH-1 to 0 by plain overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Drop counter. A clear coinciding with an overflow leaves the count at 1
  // so that drop is not lost; otherwise the count saturates at all-ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (clear_drops) begin
      drop_count <= overflow ? CNT_WIDTH'(1) : '0;
    end else if (overflow && !(&drop_count)) begin
      drop_count <= drop_count + CNT_WIDTH'(1);
    end
  end

endmodule
